// File: rtl/bw_row_integral.sv
// Running per-row sum of a 4-bit grayscale pixel stream, tagged with column/row
// position and end-of-line/end-of-frame flags; one registered cycle of latency.
module bw_row_integral #(
    parameter int LINE_WIDTH = 640,
    parameter int LINES      = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [3:0]  in_bw,
    output logic        out_valid,
    output logic [13:0] out_sum,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic        out_eol,
    output logic        out_eof,
    output logic        err_sync
);

    // Handshake: a pixel is taken on every rising edge where in_valid=1 (no
    // back-pressure); its result is presented for exactly one cycle with out_valid=1.

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [9:0] X_LAST = 10'(LINE_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(LINES - 1);

    state_t      state, state_nxt;
    logic        valid_nxt;
    logic [13:0] sum_nxt;
    logic [9:0]  x_nxt;
    logic [8:0]  y_nxt;
    logic        eol_nxt, eof_nxt, err_nxt;
    logic        start, step;

    assign start = in_valid & in_sof;
    assign step  = in_valid & ~in_sof & (state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        sum_nxt   = out_sum;
        x_nxt     = out_x;
        y_nxt     = out_y;
        eol_nxt   = out_eol;
        eof_nxt   = out_eof;
        err_nxt   = err_sync;
        if (start) begin
            // A sof while a frame is open means the previous frame was cut short.
            err_nxt   = (state == ACTIVE);
            state_nxt = ACTIVE;
            valid_nxt = 1'b1;
            sum_nxt   = {10'd0, in_bw};
            x_nxt     = 10'd0;
            y_nxt     = 9'd0;
        end else if (step) begin
            valid_nxt = 1'b1;
            if (out_eol) begin
                sum_nxt = {10'd0, in_bw};
                x_nxt   = 10'd0;
                y_nxt   = out_y + 9'd1;
            end else begin
                sum_nxt = out_sum + {10'd0, in_bw};
                x_nxt   = out_x + 10'd1;
            end
        end
        if (start || step) begin
            eol_nxt = (x_nxt == X_LAST);
            eof_nxt = eol_nxt && (y_nxt == Y_LAST);
            if (eof_nxt) begin
                state_nxt = WAIT_SOF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= 14'd0;
            out_x     <= 10'd0;
            out_y     <= 9'd0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            out_valid <= valid_nxt;
            out_sum   <= sum_nxt;
            out_x     <= x_nxt;
            out_y     <= y_nxt;
            out_eol   <= eol_nxt;
            out_eof   <= eof_nxt;
            err_sync  <= err_nxt;
        end
    end

endmodule
